// File: rtl/run_ctrl_pkg.sv
// Shared types for the X9 run/handshake controller.
// Optional watchdog is enabled with RUN_CTRL_WDOG_EN.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    localparam logic [8:0] DEF_HALT_CODE = 9'h1FF;

    typedef struct packed {
        logic       wr_en;
        logic [7:0] addr;
        logic [7:0] dat;
    } mem_req_t;

endpackage

// File: rtl/run_cycle_ctr.sv
// Clear/enable saturating cycle counter with watchdog limit compare.
// The limit compare exists only when RUN_CTRL_WDOG_EN is defined.
module run_cycle_ctr #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] cnt,
    output logic          at_limit
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef RUN_CTRL_WDOG_EN
    assign at_limit = (cnt == limit);
`else
    logic unused_limit;
    assign unused_limit = ^limit;
    assign at_limit     = 1'b0;
`endif

endmodule

// File: rtl/run_ctrl.sv
// Run/handshake controller: holds the X9 core in reset while the host owns data memory,
// runs the program to halt, then hands memory back. Watchdog enabled by RUN_CTRL_WDOG_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned   D         = 12,
    parameter int unsigned   CW        = 16,
    parameter logic [D-1:0]  END_PC    = {D{1'b1}},
    parameter logic [8:0]    HALT_CODE = DEF_HALT_CODE,
    parameter logic [CW-1:0] MAX_CYC   = {CW{1'b1}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic          timeout,
    output logic          core_rst,
    output logic          core_en,
    input  logic [D-1:0]  prog_ctr,
    input  logic [8:0]    mach_code,
    input  logic          host_wr_en,
    input  logic [7:0]    host_addr,
    input  logic [7:0]    host_dat,
    input  logic          core_wr_en,
    input  logic [7:0]    core_addr,
    input  logic [7:0]    core_dat,
    output logic          mem_wr_en,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_dat,
    output logic [CW-1:0] cyc_cnt,
    output logic          host_err
);

    run_state_t state_q, state_d;
    logic       halt, at_limit, wdog_hit, host_err_d;
    mem_req_t   host_req, core_req, mem_req;

    assign halt     = (mach_code == HALT_CODE) || (prog_ctr == END_PC);
    // A halt in the same cycle as the watchdog limit is a normal finish.
    assign wdog_hit = at_limit && !halt;

    run_cycle_ctr #(
        .CW (CW)
    ) u_cyc (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q == START),
        .en       (state_q == RUN),
        .limit    (MAX_CYC - CW'(1)),
        .cnt      (cyc_cnt),
        .at_limit (at_limit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = START;
            START:   state_d = RUN;
            RUN:     if (halt || wdog_hit) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A host write during START still flags, even though START clears the old flag.
    always_comb begin
        host_err_d = (state_q == START) ? 1'b0 : host_err;
        if (host_wr_en && (state_q inside {START, RUN, DRAIN})) host_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            host_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            host_err <= host_err_d;
        end
    end

`ifdef RUN_CTRL_WDOG_EN
    logic timeout_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (state_q == START) begin
            timeout_q <= 1'b0;
        end else if ((state_q == RUN) && wdog_hit) begin
            timeout_q <= 1'b1;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign done     = (state_q == DONE);
    assign core_rst = (state_q == IDLE) || (state_q == START);
    assign core_en  = (state_q == RUN);

    assign host_req = '{wr_en: host_wr_en, addr: host_addr, dat: host_dat};
    assign core_req = '{wr_en: core_wr_en, addr: core_addr, dat: core_dat};

    always_comb begin
        mem_req = host_req;
        if (state_q == RUN) begin
            mem_req = core_req;
        end else if (state_q == DRAIN) begin
            mem_req       = core_req;
            mem_req.wr_en = 1'b0;
        end
    end

    assign mem_wr_en = mem_req.wr_en;
    assign mem_addr  = mem_req.addr;
    assign mem_dat   = mem_req.dat;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl with a small core/PC model and a dat_mem model.
// Watchdog expectations follow RUN_CTRL_WDOG_EN.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset, req;
    logic        done, timeout, core_rst, core_en;
    logic [11:0] pc, halt_pc;
    logic [8:0]  mach_code;
    logic        host_wr_en, core_wr_en, mem_wr_en, host_err;
    logic [7:0]  host_addr, host_dat, core_addr, core_dat, mem_addr, mem_dat;
    logic [15:0] cyc_cnt;
    logic [7:0]  dat_mem [256];

    typedef struct {
        int unsigned cyc;
        bit          to;
        bit          err;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .D       (12),
        .CW      (16),
        .END_PC  (12'd40),
        .MAX_CYC (16'd20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .timeout    (timeout),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .prog_ctr   (pc),
        .mach_code  (mach_code),
        .host_wr_en (host_wr_en),
        .host_addr  (host_addr),
        .host_dat   (host_dat),
        .core_wr_en (core_wr_en),
        .core_addr  (core_addr),
        .core_dat   (core_dat),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat    (mem_dat),
        .cyc_cnt    (cyc_cnt),
        .host_err   (host_err)
    );

    // Core PC model and data memory
    always @(posedge clk) begin
        if (core_rst) pc <= '0;
        else if (core_en) pc <= pc + 12'd1;
        if (mem_wr_en) dat_mem[mem_addr] <= mem_dat;
    end
    assign mach_code = (pc == halt_pc) ? 9'h1FF : 9'h0A5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("cyc_cnt", cyc_cnt, e.cyc);
        check("timeout", timeout, e.to);
        check("host_err", host_err, e.err);
    endtask

    // Run one program to done; optionally poke a host write at 8'h20 in the first RUN cycle.
    task automatic run_prog(input logic [11:0] hpc, input int unsigned exp_cyc, input bit exp_to,
                            input bit exp_err, input bit poke);
        int  n = 0;
        bit  seen = 0;
        bit  poked = 0;
        halt_pc = hpc;
        sb.push_back('{cyc: exp_cyc, to: exp_to, err: exp_err});
        req = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            host_wr_en = 1'b0;
            if (done) begin
                n    = i;
                seen = 1;
                break;
            end
            if (poke && core_en && !poked) begin
                poked      = 1;
                host_wr_en = 1'b1;
                host_addr  = 8'h20;
                host_dat   = 8'hEE;
                #1;
                check("poke_mem_we", mem_wr_en, 1'b0);
                check("poke_mem_addr", mem_addr, 8'h3C);
            end
        end
        check("done_seen", seen, 1'b1);
        check("done_lat", n, exp_cyc + 3);
        pop_check();
        tick();
        check("done_hold", done, 1'b1);
        req = 1'b0;
        tick();
        check("idle_done", done, 1'b0);
        check("idle_rst", core_rst, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dat_mem[i] = 8'h00;
        halt_pc    = 12'hFFF;
        reset      = 1'b0;
        req        = 1'b0;
        host_wr_en = 1'b0;
        host_addr  = 8'h33;
        host_dat   = 8'hC3;
        core_wr_en = 1'b1;
        core_addr  = 8'h41;
        core_dat   = 8'hFF;

        // 1: reset
        repeat (3) tick();
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_core_en", core_en, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cyc", cyc_cnt, 16'd0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_host_err", host_err, 1'b0);
        check("rst_mem_we", mem_wr_en, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h33);
        check("rst_mem_dat", mem_dat, 8'hC3);
        reset = 1'b1;
        tick();

        // 2: host preload then a 7-cycle run writing from the core
        host_wr_en = 1'b1;
        host_addr  = 8'h10;
        host_dat   = 8'h5A;
        #1;
        check("idle_mem_we", mem_wr_en, 1'b1);
        tick();
        host_wr_en = 1'b0;
        check("preload", dat_mem[8'h10], 8'h5A);
        check("core_drop_idle", dat_mem[8'h41], 8'h00);
        core_addr = 8'h40;
        core_dat  = 8'h77;
        run_prog(12'd6, 7, 1'b0, 1'b0, 1'b0);
        check("core_write", dat_mem[8'h40], 8'h77);
        core_wr_en = 1'b0;

        // 3: halt in the first RUN cycle; DRAIN blocks the core write
        halt_pc = 12'd0;
        sb.push_back('{cyc: 1, to: 1'b0, err: 1'b0});
        req        = 1'b1;
        core_wr_en = 1'b1;
        core_addr  = 8'h50;
        core_dat   = 8'h11;
        tick();
        tick();
        check("halt_core_en", core_en, 1'b1);
        check("halt_mem_we", mem_wr_en, 1'b1);
        tick();
        core_addr = 8'h51;
        core_dat  = 8'h22;
        #1;
        check("halt_written", dat_mem[8'h50], 8'h11);
        check("drain_mem_we", mem_wr_en, 1'b0);
        check("drain_mem_addr", mem_addr, 8'h51);
        check("drain_core_en", core_en, 1'b0);
        check("drain_core_rst", core_rst, 1'b0);
        tick();
        check("drain_done", done, 1'b1);
        pop_check();
        check("drain_blocked", dat_mem[8'h51], 8'h00);
        core_wr_en = 1'b0;
        req        = 1'b0;
        tick();

        // 4: host write while core owns memory
        core_addr = 8'h3C;
        run_prog(12'd4, 5, 1'b0, 1'b1, 1'b1);
        check("host_dropped", dat_mem[8'h20], 8'h00);
        check("err_sticky", host_err, 1'b1);

        // 5: no halt instruction; watchdog or END_PC ends the run
`ifdef RUN_CTRL_WDOG_EN
        run_prog(12'hFFF, 20, 1'b1, 1'b0, 1'b0);
`else
        run_prog(12'hFFF, 41, 1'b0, 1'b0, 1'b0);
`endif
        run_prog(12'd19, 20, 1'b0, 1'b0, 1'b0);
        run_prog(12'd2, 3, 1'b0, 1'b0, 1'b0);

        // 6: reset in RUN cycle 4
        halt_pc = 12'd100;
        req     = 1'b1;
        repeat (5) tick();
        check("mid_core_en", core_en, 1'b1);
        check("mid_cyc", cyc_cnt, 16'd3);
        reset      = 1'b0;
        core_wr_en = 1'b1;
        core_addr  = 8'h60;
        core_dat   = 8'h99;
        tick();
        check("mrst_core_rst", core_rst, 1'b1);
        check("mrst_core_en", core_en, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_cyc", cyc_cnt, 16'd0);
        check("mrst_inflight", dat_mem[8'h60], 8'h99);
        reset      = 1'b1;
        req        = 1'b0;
        core_wr_en = 1'b0;
        tick();
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
